// File: rtl/n_divide_prog.sv
// rtl/n_divide_prog.sv - runtime-programmable 50%-duty integer clock divider; optional phase slip under DIV_SLIP_EN
`timescale 1ns/1ps
module n_divide_prog #(
  parameter int DIV_W       = 6,
  parameter int DIV_DEFAULT = 3
) (
  input  logic             clk_out,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div_n,
  input  logic             div_load,
`ifdef DIV_SLIP_EN
  input  logic             slip_req,
`endif
  output logic             clk_fb,
  output logic [DIV_W-1:0] div_active,
  output logic             div_busy,
  output logic             load_err,
  output logic             cycle_pulse
);

  localparam logic [DIV_W-1:0] DEF_N = DIV_W'(DIV_DEFAULT);
  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] MIN_N = DIV_W'(2);

  logic [DIV_W-1:0] cnt_pos_q, cnt_pos_d;
  logic [DIV_W-1:0] active_n_q, active_n_d;
  logic [DIV_W-1:0] pending_n_q, pending_n_d;
  logic             busy_q, busy_d;
  logic             load_err_q, load_err_d;
  logic             cycle_pulse_q, cycle_pulse_d;
  logic             clk_pos_q, clk_pos_d;
  logic             clk_neg_q, clk_neg_d;
  logic             odd_sel_q, odd_sel_d;
`ifdef DIV_SLIP_EN
  logic             slip_armed_q, slip_armed_d;
  logic             slip_hold_q, slip_hold_d;
`endif

  logic [DIV_W:0]   high_len;
  logic             term;
  logic             hold;
  logic             wrap;
  logic             load_ok;
  logic             apply;

  // Posedge next-state: period counter, ratio handshake, high-phase generation and optional slip
  always_comb begin
    high_len      = ({1'b0, active_n_q} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
    term          = (cnt_pos_q == active_n_q - ONE);
    hold          = 1'b0;
`ifdef DIV_SLIP_EN
    // A slip repeats the terminal count once; the ratio swap waits for the real wrap after it
    hold          = term && !slip_hold_q && (slip_armed_q || slip_req);
`endif
    wrap          = term && !hold;
    load_ok       = div_load && (div_n >= MIN_N);
    // Uses the pending value from before this edge, so a load on the wrap edge waits one period
    apply         = wrap && busy_q;
    cnt_pos_d     = wrap ? '0 : (hold ? cnt_pos_q : cnt_pos_q + ONE);
    clk_pos_d     = ({1'b0, cnt_pos_q} < high_len);
    active_n_d    = apply ? pending_n_q : active_n_q;
    pending_n_d   = load_ok ? div_n : pending_n_q;
    busy_d        = load_ok | (busy_q & ~apply);
    load_err_d    = div_load & ~load_ok;
    cycle_pulse_d = wrap;
`ifdef DIV_SLIP_EN
    slip_hold_d   = hold;
    if (wrap) begin
      slip_armed_d = slip_req;
    end else if (hold) begin
      slip_armed_d = 1'b0;
    end else begin
      slip_armed_d = slip_armed_q | slip_req;
    end
`endif
  end

  // Posedge state register
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      cnt_pos_q     <= '0;
      active_n_q    <= DEF_N;
      pending_n_q   <= DEF_N;
      busy_q        <= 1'b0;
      load_err_q    <= 1'b0;
      cycle_pulse_q <= 1'b0;
      clk_pos_q     <= 1'b0;
`ifdef DIV_SLIP_EN
      slip_armed_q  <= 1'b0;
      slip_hold_q   <= 1'b0;
`endif
    end else begin
      cnt_pos_q     <= cnt_pos_d;
      active_n_q    <= active_n_d;
      pending_n_q   <= pending_n_d;
      busy_q        <= busy_d;
      load_err_q    <= load_err_d;
      cycle_pulse_q <= cycle_pulse_d;
      clk_pos_q     <= clk_pos_d;
`ifdef DIV_SLIP_EN
      slip_armed_q  <= slip_armed_d;
      slip_hold_q   <= slip_hold_d;
`endif
    end
  end

  // Negedge next-state: half-cycle copy of clk_pos; odd/even form only switches while both copies sit low
  always_comb begin
    clk_neg_d = clk_pos_q;
    odd_sel_d = odd_sel_q;
    if (!clk_pos_q && !clk_neg_d) begin
      odd_sel_d = active_n_q[0];
    end
  end

  // Negedge state register
  always_ff @(negedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      clk_neg_q <= 1'b0;
      odd_sel_q <= DEF_N[0];
    end else begin
      clk_neg_q <= clk_neg_d;
      odd_sel_q <= odd_sel_d;
    end
  end

  // Odd ratios trim the high phase by half a cycle using the negedge copy
  assign clk_fb      = odd_sel_q ? (clk_pos_q & clk_neg_q) : clk_pos_q;
  assign div_active  = active_n_q;
  assign div_busy    = busy_q;
  assign load_err    = load_err_q;
  assign cycle_pulse = cycle_pulse_q;

endmodule

// File: tb/tb_n_divide_prog.sv
// tb/tb_n_divide_prog.sv - randomized self-checking bench for n_divide_prog against a period-schedule model
`timescale 1ns/1ps
module tb_n_divide_prog;
  localparam int DIV_W       = 6;
  localparam int DIV_DEFAULT = 3;

  logic             clk_out  = 1'b0;
  logic             rst_n    = 1'b1;
  logic [DIV_W-1:0] div_n    = '0;
  logic             div_load = 1'b0;
`ifdef DIV_SLIP_EN
  logic             slip_req = 1'b0;
`endif
  logic             clk_fb;
  logic [DIV_W-1:0] div_active;
  logic             div_busy;
  logic             load_err;
  logic             cycle_pulse;

  n_divide_prog #(.DIV_W(DIV_W), .DIV_DEFAULT(DIV_DEFAULT)) dut (
    .clk_out     (clk_out),
    .rst_n       (rst_n),
    .div_n       (div_n),
    .div_load    (div_load),
`ifdef DIV_SLIP_EN
    .slip_req    (slip_req),
`endif
    .clk_fb      (clk_fb),
    .div_active  (div_active),
    .div_busy    (div_busy),
    .load_err    (load_err),
    .cycle_pulse (cycle_pulse)
  );

  always #5 clk_out = ~clk_out;

  int  checks   = 0;
  int  failures = 0;

  // model: absolute edge count and the edge index of the next period end
  int  cyc, next_bnd, m_act, m_pend;
  bit  m_busy, m_err, m_cp, m_armed, m_slipped, slip_seen;

  bit  mon_en = 1'b0, have_r = 1'b0, have_f = 1'b0;
  time t_r, t_f;
  int  mon_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; m_act = DIV_DEFAULT; m_pend = DIV_DEFAULT; next_bnd = DIV_DEFAULT - 1;
    m_busy = 0; m_err = 0; m_cp = 0; m_armed = 0; m_slipped = 0; slip_seen = 0;
  endtask

  task automatic step();
    bit term, ok;
    @(posedge clk_out);
    term = (cyc == next_bnd);
    ok   = div_load && (int'(div_n) >= 2);
`ifdef DIV_SLIP_EN
    if (term && !m_slipped && (m_armed || slip_req)) begin
      term = 0; next_bnd++; m_slipped = 1; m_armed = 0; slip_seen = 1;
    end else if (!term && !m_slipped && slip_req) begin
      m_armed = 1;
    end
`endif
    m_err = div_load && !ok;
    m_cp  = term;
    if (term) begin
      if (m_busy) begin m_act = m_pend; m_busy = 0; end
      next_bnd = cyc + m_act;
`ifdef DIV_SLIP_EN
      m_slipped = 0; m_armed = slip_req;
`endif
    end
    if (ok) begin m_pend = int'(div_n); m_busy = 1; end
    cyc++;
    #1;
    check("div_active", 32'(div_active), 32'(m_act));
    check("div_busy", 32'(div_busy), 32'(m_busy));
    check("load_err", 32'(load_err), 32'(m_err));
    check("cycle_pulse", 32'(cycle_pulse), 32'(m_cp));
    div_load = 1'b0;
`ifdef DIV_SLIP_EN
    slip_req = 1'b0;
`endif
  endtask

  task automatic wait_boundary(output int n);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      step(); n++;
      if (cycle_pulse === 1'b1) break;
    end
    check("boundary_seen", 32'(cycle_pulse), 32'd1);
  endtask

  task automatic do_reset();
    mon_en = 0; have_r = 0; have_f = 0;
    rst_n = 1'b0;
    #1;
    check("rst_clk_fb", 32'(clk_fb), 32'd0);
    check("rst_div_busy", 32'(div_busy), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_cycle_pulse", 32'(cycle_pulse), 32'd0);
    check("rst_div_active", 32'(div_active), 32'(DIV_DEFAULT));
    model_reset();
    @(negedge clk_out); #2;
    rst_n = 1'b1; mon_en = 1;
  endtask

  // clk_fb waveform: exact high/low/period at a steady ratio, at least half a cycle across changes
  always @(posedge clk_fb) begin
    if (mon_en) begin
      if (have_f) begin
        if (mon_n == m_act && !slip_seen) begin
          check("fb_low_time", 32'($time - t_f), 32'(5 * mon_n));
          check("fb_period", 32'($time - t_r), 32'(10 * mon_n));
        end else begin
          check("fb_low_min", 32'(($time - t_f) >= 5), 32'd1);
        end
      end
      t_r = $time; mon_n = m_act; have_r = 1; slip_seen = 0;
    end
  end

  // every high phase lasts N/2 clk_out cycles
  always @(negedge clk_fb) begin
    if (mon_en && have_r) begin
      check("fb_high_time", 32'($time - t_r), 32'(5 * mon_n));
      t_f = $time; have_f = 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1;
    do_reset();
    for (int i = 0; i < 12; i++) step();

    wait_boundary(n); step();
    div_n = 6'd4; div_load = 1'b1; step();
    check("busy_after_load4", 32'(div_busy), 32'd1);
    wait_boundary(n);
    check("active_is_4", 32'(div_active), 32'd4);
    for (int i = 0; i < 12; i++) step();

    wait_boundary(n);
    div_n = 6'd7; div_load = 1'b1; step();
    div_n = 6'd5; div_load = 1'b1; step();
    wait_boundary(n);
    check("last_load_wins", 32'(div_active), 32'd5);
    wait_boundary(n);
    check("period_5", 32'(n), 32'd5);

    div_n = 6'd1; div_load = 1'b1; step();
    check("err_on_1", 32'(load_err), 32'd1);
    div_n = 6'd0; div_load = 1'b1; step();
    check("err_on_0", 32'(load_err), 32'd1);
    check("err_keeps_active", 32'(div_active), 32'd5);
    check("err_keeps_idle", 32'(div_busy), 32'd0);
    step();
    check("err_one_cycle", 32'(load_err), 32'd0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        div_load = 1'b1;
        div_n = DIV_W'($urandom_range(0, 40));
      end
      step();
    end

    div_n = 6'd5; div_load = 1'b1; step();
    wait_boundary(n); wait_boundary(n);
    check("active_is_5", 32'(div_active), 32'd5);
    div_n = 6'd9; div_load = 1'b1; step();
    check("pending_9", 32'(div_busy), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (clk_fb === 1'b1) break;
      step();
    end
    check("fb_high_before_reset", 32'(clk_fb), 32'd1);
    do_reset();
    for (int i = 0; i < 12; i++) step();

`ifdef DIV_SLIP_EN
    div_n = 6'd4; div_load = 1'b1; step();
    wait_boundary(n); wait_boundary(n);
    slip_req = 1'b1; step();
    slip_req = 1'b1; step();
    wait_boundary(n);
    check("slip_period_5", 32'(n + 2), 32'd5);
    wait_boundary(n);
    check("after_slip_period_4", 32'(n), 32'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
